// File: rtl/captura_resultado.sv
// Result capture FIFO for the 2-bit subtractor: buffers {TS,S}, decodes the head entry to magnitude/7-segment.
// Optional CAPTURA_ESTATISTICA_EN adds a saturating count of negative results popped (contador_neg).
module captura_resultado #(
    parameter int PROFUNDIDADE = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] S,
    input  logic       TS,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [2:0] valor,
    output logic       negativo,
    output logic [1:0] magnitude,
    output logic [6:0] seg,
    output logic [4:0] contagem,
    output logic       estouro,
    input  logic       limpa
`ifdef CAPTURA_ESTATISTICA_EN
    ,
    output logic [7:0] contador_neg
`endif
);

    localparam int PW = (PROFUNDIDADE > 1) ? $clog2(PROFUNDIDADE) : 1;
    localparam logic [4:0] CHEIO = 5'(PROFUNDIDADE);

    logic [2:0]    mem [PROFUNDIDADE];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [2:0]    head;
    logic          push;
    logic          pop;

    assign in_ready  = (contagem < CHEIO);
    assign out_valid = (contagem != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign head      = mem[rd_ptr];

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            contagem <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   contagem <= contagem + 5'd1;
                2'b01:   contagem <= contagem - 5'd1;
                default: contagem <= contagem;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {TS, S};
    end

    // Overflow set takes priority over a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                     estouro <= 1'b0;
        else if (in_valid && !in_ready) estouro <= 1'b1;
        else if (limpa)                 estouro <= 1'b0;
    end

`ifdef CAPTURA_ESTATISTICA_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                   contador_neg <= '0;
        else if (limpa)                               contador_neg <= '0;
        else if (pop && head[2] && contador_neg != '1) contador_neg <= contador_neg + 8'd1;
    end
`endif

    always_comb begin
        valor     = '0;
        negativo  = 1'b0;
        magnitude = '0;
        seg       = 7'h7F;
        if (out_valid) begin
            valor    = head;
            negativo = head[2];
            case (head)
                3'b000:  magnitude = 2'd0;
                3'b001:  magnitude = 2'd1;
                3'b010:  magnitude = 2'd2;
                3'b011:  magnitude = 2'd3;
                3'b100:  magnitude = 2'd3;
                3'b101:  magnitude = 2'd3;
                3'b110:  magnitude = 2'd2;
                default: magnitude = 2'd1;
            endcase
            case (magnitude)
                2'd0:    seg = 7'h40;
                2'd1:    seg = 7'h79;
                2'd2:    seg = 7'h24;
                default: seg = 7'h30;
            endcase
        end
    end

endmodule

// File: tb/tb_captura_resultado.sv
// Self-checking bench for captura_resultado: decode table, directed FIFO sequences, randomized run vs queue model.
module tb_captura_resultado;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] S;
    logic       TS;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] valor;
    logic       negativo;
    logic [1:0] magnitude;
    logic [6:0] seg;
    logic [4:0] contagem;
    logic       estouro;
    logic       limpa;
`ifdef CAPTURA_ESTATISTICA_EN
    logic [7:0] contador_neg;
`endif

    captura_resultado #(.PROFUNDIDADE(D)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .S         (S),
        .TS        (TS),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .valor     (valor),
        .negativo  (negativo),
        .magnitude (magnitude),
        .seg       (seg),
        .contagem  (contagem),
        .estouro   (estouro),
        .limpa     (limpa)
`ifdef CAPTURA_ESTATISTICA_EN
        ,
        .contador_neg (contador_neg)
`endif
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    logic [2:0] q[$];
    logic       est_m;
`ifdef CAPTURA_ESTATISTICA_EN
    int         neg_m;
`endif

    typedef struct {
        logic [2:0] v;
        logic       neg;
        logic [1:0] mag;
        logic [6:0] sg;
    } vec_t;

    vec_t tabela[8];

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    function automatic int mag_of(input logic [2:0] v);
        int s;
        s = (v[2]) ? int'(v) - 8 : int'(v);
        if (s < 0) s = -s;
        if (s > 3) s = 3;
        return s;
    endfunction

    function automatic int seg_of(input int m);
        case (m)
            0:       return 'h40;
            1:       return 'h79;
            2:       return 'h24;
            default: return 'h30;
        endcase
    endfunction

    task automatic check_model();
        int n;
        n = q.size();
        chk("contagem",  int'(contagem),  n);
        chk("in_ready",  int'(in_ready),  (n < D) ? 1 : 0);
        chk("out_valid", int'(out_valid), (n != 0) ? 1 : 0);
        chk("estouro",   int'(estouro),   int'(est_m));
        if (n != 0) begin
            chk("valor",     int'(valor),     int'(q[0]));
            chk("negativo",  int'(negativo),  int'(q[0][2]));
            chk("magnitude", int'(magnitude), mag_of(q[0]));
            chk("seg",       int'(seg),       seg_of(mag_of(q[0])));
        end else begin
            chk("valor_vazio",     int'(valor),     0);
            chk("negativo_vazio",  int'(negativo),  0);
            chk("magnitude_vazio", int'(magnitude), 0);
            chk("seg_vazio",       int'(seg),       'h7F);
        end
`ifdef CAPTURA_ESTATISTICA_EN
        chk("contador_neg", int'(contador_neg), neg_m);
`endif
    endtask

    // Called just after a falling edge: drives one cycle and checks the result at the next falling edge.
    task automatic drive(input logic iv, input logic [2:0] d, input logic ordy, input logic lim);
        bit p_push, p_pop, p_ovf, p_neg;
        in_valid  = iv;
        {TS, S}   = d;
        out_ready = ordy;
        limpa     = lim;
        p_push = iv && (q.size() < D);
        p_pop  = ordy && (q.size() != 0);
        p_ovf  = iv && (q.size() >= D);
        p_neg  = p_pop && q[0][2];
        @(posedge clk);
        if (p_pop)  void'(q.pop_front());
        if (p_push) q.push_back(d);
        if (p_ovf)      est_m = 1'b1;
        else if (lim)   est_m = 1'b0;
`ifdef CAPTURA_ESTATISTICA_EN
        if (lim)                      neg_m = 0;
        else if (p_neg && neg_m < 255) neg_m++;
`else
        if (p_neg) p_neg = 1'b0;
`endif
        @(negedge clk);
        check_model();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; limpa = 1'b0; {TS, S} = 3'b000;
        q.delete();
        est_m = 1'b0;
`ifdef CAPTURA_ESTATISTICA_EN
        neg_m = 0;
`endif
        #1;
        check_model();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_model();
    endtask

    logic [2:0] seq[8];
    logic [2:0] cheio[4];

    initial begin
        tabela[0] = '{3'b111, 1'b1, 2'd1, 7'h79};
        tabela[1] = '{3'b000, 1'b0, 2'd0, 7'h40};
        tabela[2] = '{3'b001, 1'b0, 2'd1, 7'h79};
        tabela[3] = '{3'b010, 1'b0, 2'd2, 7'h24};
        tabela[4] = '{3'b011, 1'b0, 2'd3, 7'h30};
        tabela[5] = '{3'b100, 1'b1, 2'd3, 7'h30};
        tabela[6] = '{3'b101, 1'b1, 2'd3, 7'h30};
        tabela[7] = '{3'b110, 1'b1, 2'd2, 7'h24};
        cheio = '{3'b011, 3'b000, 3'b110, 3'b001};
        seq   = '{3'b001, 3'b010, 3'b111, 3'b100, 3'b011, 3'b101, 3'b000, 3'b110};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; limpa = 1'b0; {TS, S} = 3'b000;
        do_reset();

        // Decode table: push into empty FIFO, head visible next cycle, then pop.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, tabela[i].v, 1'b0, 1'b0);
            chk("tab_out_valid", int'(out_valid), 1);
            chk("tab_valor",     int'(valor),     int'(tabela[i].v));
            chk("tab_negativo",  int'(negativo),  int'(tabela[i].neg));
            chk("tab_magnitude", int'(magnitude), int'(tabela[i].mag));
            chk("tab_seg",       int'(seg),       int'(tabela[i].sg));
            drive(1'b0, 3'b000, 1'b1, 1'b0);
            chk("tab_vazio", int'(out_valid), 0);
        end
`ifdef CAPTURA_ESTATISTICA_EN
        chk("neg_table", int'(contador_neg), 4);
`endif

        // Fill, overflow, clear precedence.
        for (int i = 0; i < 4; i++) drive(1'b1, cheio[i], 1'b0, 1'b0);
        chk("cheio_contagem", int'(contagem), 4);
        chk("cheio_in_ready", int'(in_ready), 0);
        drive(1'b1, 3'b010, 1'b0, 1'b0);
        chk("ovf_estouro", int'(estouro), 1);
        chk("ovf_head",    int'(valor),   3);
        chk("ovf_count",   int'(contagem), 4);
        drive(1'b1, 3'b010, 1'b0, 1'b1);
        chk("set_vence_limpa", int'(estouro), 1);
        drive(1'b0, 3'b000, 1'b0, 1'b1);
        chk("limpa_estouro", int'(estouro), 0);

        // Drain in order.
        for (int i = 0; i < 4; i++) begin
            chk("drain_valor", int'(valor), int'(cheio[i]));
            chk("drain_seg",   int'(seg),   seg_of(mag_of(cheio[i])));
            drive(1'b0, 3'b000, 1'b1, 1'b0);
        end
        chk("drain_out_valid", int'(out_valid), 0);
        chk("drain_seg_blank", int'(seg), 'h7F);

        // Simultaneous push/pop at occupancy 2, wrapping the pointers.
        drive(1'b1, seq[0], 1'b0, 1'b0);
        drive(1'b1, seq[1], 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, seq[i+2], 1'b1, 1'b0);
            chk("pp_contagem", int'(contagem), 2);
            chk("pp_ordem",    int'(valor),    int'(seq[i+1]));
        end

        // Asynchronous reset mid-cycle with three entries buffered.
        drive(1'b0, 3'b000, 1'b1, 1'b0);
        drive(1'b1, 3'b101, 1'b0, 1'b0);
        drive(1'b1, 3'b110, 1'b0, 1'b0);
        chk("pre_rst_contagem", int'(contagem), 3);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", int'(out_valid), 0);
        chk("arst_contagem",  int'(contagem),  0);
        chk("arst_seg",       int'(seg),       'h7F);
        chk("arst_in_ready",  int'(in_ready),  1);
        q.delete();
        est_m = 1'b0;
`ifdef CAPTURA_ESTATISTICA_EN
        neg_m = 0;
`endif
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 3'b100, 1'b0, 1'b0);
        chk("pos_rst_push", int'(valor), 4);
        chk("pos_rst_mag",  int'(magnitude), 3);
        drive(1'b0, 3'b000, 1'b1, 1'b0);
`ifdef CAPTURA_ESTATISTICA_EN
        chk("neg_pop_100", int'(contador_neg), 1);
`endif

        // Randomized traffic against the queue model.
        for (int i = 0; i < 600; i++) begin
            int pr;
            pr = (i < 300) ? 25 : 75;
            drive(($urandom % 4) != 0, 3'($urandom), ($urandom % 100) < pr, ($urandom % 8) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/captura_resultado.md
CAPTURA_RESULTADO -- requirements
Module: captura_resultado

Interface
REQ-001 SHALL have parameter PROFUNDIDADE, default 4, meaning result FIFO depth in entries (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  upstream subtractor result {TS,S} is valid this cycle.
REQ-005 SHALL have port in_ready  output  1  block can accept a result this cycle.
REQ-006 SHALL have port S  input  2  difference bits from the 2-bit subtractor.
REQ-007 SHALL have port TS  input  1  final borrow out of the 2-bit subtractor.
REQ-008 SHALL have port out_valid  output  1  head entry is present on the result outputs.
REQ-009 SHALL have port out_ready  input  1  consumer accepts the head entry this cycle.
REQ-010 SHALL have port valor  output  3  head entry {TS,S} as 3-bit two's complement.
REQ-011 SHALL have port negativo  output  1  head entry sign (valor[2]).
REQ-012 SHALL have port magnitude  output  2  absolute value of the head entry.
REQ-013 SHALL have port seg  output  7  active-low 7-segment code of magnitude, bit order gfedcba.
REQ-014 SHALL have port contagem  output  5  current FIFO occupancy.
REQ-015 SHALL have port estouro  output  1  sticky overflow flag.
REQ-016 SHALL have port limpa  input  1  synchronous clear of estouro.

Function
REQ-017 SHALL push {TS,S} into the FIFO when in_valid && in_ready; in_ready = (contagem < PROFUNDIDADE), combinational from registered state.
REQ-018 SHALL pop the head when out_valid && out_ready; out_valid = (contagem != 0).
REQ-019 SHALL have 1-cycle latency: a push into an empty FIFO makes out_valid = 1 in the following cycle; no same-cycle bypass.
REQ-020 SHALL, on simultaneous push and pop with 0 < contagem < PROFUNDIDADE, keep contagem unchanged and advance both pointers.
REQ-021 SHALL hold in_ready = 0 when full, so a pop while full frees space only from the next cycle.
REQ-022 SHALL wrap read and write pointers modulo PROFUNDIDADE.
REQ-023 SHALL set estouro when in_valid && !in_ready, and hold it until limpa; if set and limpa occur in the same cycle, set wins.
REQ-024 SHALL drive valor, negativo, magnitude and seg from the head entry when out_valid = 1; otherwise valor = 0, negativo = 0, magnitude = 0 and seg = 7'h7F (blank).
REQ-025 SHALL compute magnitude = valor for valor >= 0 and -valor for valor < 0; 3'b100 (-4) saturates to 2'd3.
REQ-026 SHALL encode seg as 0 = 7'h40, 1 = 7'h79, 2 = 7'h24, 3 = 7'h30.
REQ-027 SHALL leave FIFO contents unchanged on a pop attempt while empty or a push attempt while full.

Reset
REQ-028 SHALL, while rst_n = 0, immediately force pointers = 0, contagem = 0, out_valid = 0, estouro = 0, valor = 0, negativo = 0, magnitude = 0 and seg = 7'h7F.
REQ-029 SHALL discard all buffered entries on reset mid-operation; in_ready reads 1 during reset and after it.
REQ-030 SHALL accept the first push on the first rising edge after rst_n deasserts.

Configuration
REQ-031 SHALL, when macro CAPTURA_ESTATISTICA_EN is defined, add output contador_neg [7:0]: reset to 0, +1 on each pop with negativo = 1, saturating at 8'hFF, cleared by limpa.
REQ-032 SHALL, without CAPTURA_ESTATISTICA_EN, omit the contador_neg port and logic; all other behaviour SHALL be identical.

Verification
REQ-033 Reset, then push {TS,S} = 3'b111 with out_ready = 0 -> next cycle out_valid = 1, valor = 3'b111, negativo = 1, magnitude = 1, seg = 7'h79.
REQ-034 Push 4 entries (011, 000, 110, 001) with out_ready = 0 -> contagem = 4, in_ready = 0; a fifth push sets estouro = 1, contents unchanged; limpa clears estouro.
REQ-035 Full FIFO, out_ready = 1 for 4 cycles -> pops in order 011, 000, 110, 001 (magnitude 3, 0, 2, 1; seg 7'h30, 7'h40, 7'h24, 7'h79), then out_valid = 0, seg = 7'h7F.
REQ-036 contagem = 2, push and pop in the same cycle -> contagem stays 2, order preserved across pointer wrap.
REQ-037 Push 3'b100 -> magnitude = 3, negativo = 1; with CAPTURA_ESTATISTICA_EN, popping it gives contador_neg = 1.
REQ-038 Assert rst_n = 0 asynchronously with contagem = 3 -> out_valid = 0, contagem = 0, seg = 7'h7F before the next clock edge.
